// File: rtl/video_row_buffer_if.sv
// video_row_buffer_if: decoder write path and scanout read path of the ping-pong row buffer.
interface video_row_buffer_if #(parameter int COLUMN_WIDTH = 9);
  logic                    video_start;
  logic [COLUMN_WIDTH-1:0] video_column;
  logic [23:0]             video_data;
  logic                    video_data_valid;
  logic                    line_start;
  logic                    pixel_read;
  logic [11:0]             pixel_data;
  logic                    pixel_valid;
  logic                    row_ready;
  logic                    underrun;
  modport master (
    input  video_start, pixel_data, pixel_valid, row_ready, underrun,
    output video_column, video_data, video_data_valid, line_start, pixel_read
  );
  modport slave (
    output video_start, pixel_data, pixel_valid, row_ready, underrun,
    input  video_column, video_data, video_data_valid, line_start, pixel_read
  );
endinterface

// File: rtl/video_row_buffer.sv
// video_row_buffer: ping-pong row store; fills one bank from the decoder while scanout reads the other.
module video_row_buffer #(
  parameter int COLUMN_WIDTH = 9,
  parameter int ROW_WORDS    = 256
) (
  input logic               i_master_clk,
  input logic               i_reset_n,
  video_row_buffer_if.slave bus
);
  localparam int AW = $clog2(ROW_WORDS);
  localparam int PW = COLUMN_WIDTH + 1;
  localparam logic [COLUMN_WIDTH-1:0] LAST    = COLUMN_WIDTH'(ROW_WORDS - 1);
  localparam logic [PW-1:0]           PIX_END = PW'(2 * ROW_WORDS);
  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;
  state_t state, state_next;
  logic live, full, read_bank, swapped, read_active;
  logic half_q, blank_q, valid_q, underrun_q;
  logic we, last_wr, do_swap, rd_go, blank;
  logic [PW-1:0] ptr;
  logic [23:0]   rd_word;
  logic [23:0]   mem [2][ROW_WORDS];
  always_comb begin
    we         = state == ACTIVE && bus.video_data_valid && bus.video_column <= LAST;
    last_wr    = we && bus.video_column == LAST;
    do_swap    = bus.line_start && (full || last_wr);
    rd_go      = bus.pixel_read && !bus.line_start;
    blank      = !read_active || !swapped || ptr >= PIX_END;
    state_next = do_swap ? REQ : (state == REQ && live) ? ACTIVE : last_wr ? IDLE : state;
  end
  // live holds REQ for one cycle after reset release so the decoder sees a clean start pulse
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= REQ;
      live        <= 1'b0;
      full        <= 1'b0;
      read_bank   <= 1'b0;
      swapped     <= 1'b0;
      read_active <= 1'b0;
      ptr         <= '0;
      half_q      <= 1'b0;
      blank_q     <= 1'b1;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state      <= state_next;
      live       <= 1'b1;
      full       <= do_swap ? 1'b0 : full | last_wr;
      read_bank  <= read_bank ^ do_swap;
      swapped    <= swapped | do_swap;
      underrun_q <= bus.line_start && !(full || last_wr);
      valid_q    <= rd_go;
      if (bus.line_start) begin
        ptr         <= '0;
        read_active <= 1'b1;
      end else if (rd_go) begin
        half_q  <= ptr[0];
        blank_q <= blank;
        if (!blank) ptr <= ptr + PW'(1);
      end
    end
  end
  always_ff @(posedge i_master_clk) begin
    if (we) mem[~read_bank][bus.video_column[AW-1:0]] <= bus.video_data;
    if (rd_go) rd_word <= mem[read_bank][ptr[AW:1]];
  end
  assign bus.video_start = state == REQ && live;
  assign bus.pixel_data  = blank_q ? 12'h000 : half_q ? rd_word[23:12] : rd_word[11:0];
  assign bus.pixel_valid = valid_q;
  assign bus.row_ready   = full;
  assign bus.underrun    = underrun_q;
endmodule
